// File: rtl/clk_div_prog.sv
// Programmable clock-enable divider: one-cycle TICK strobe every N enabled
// cycles, registered near-50% square wave, runtime divisor load with
// validity check, and an optional one-shot mode that parks in a DONE state.
// Everything runs on CLK; no derived clocks are produced.
module clk_div_prog #(
  parameter int unsigned WIDTH       = 19,
  parameter int unsigned DEFAULT_DIV = 262144
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIV_IN,
  input  logic             ONESHOT,
  output logic             TICK,
  output logic             SQ_OUT,
  output logic             DONE,
  output logic             LOAD_ERR,
  output logic [WIDTH-1:0] CNT
);

  // A divisor below 2 would make div-1 underflow; above 2^WIDTH-1 it cannot be held.
  localparam bit DivTooSmall = (DEFAULT_DIV < 2);
  localparam bit DivTooBig   = (WIDTH < 32) && (DEFAULT_DIV > ((32'd1 << WIDTH) - 32'd1));

  if (DivTooSmall || DivTooBig) begin : gen_bad_default_div
    $error("clk_div_prog: DEFAULT_DIV must satisfy 2 <= DEFAULT_DIV <= 2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);

  typedef enum logic [0:0] {
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             err_q, err_d;

  logic             load_ok;
  logic             wrap;
  logic [WIDTH-1:0] cnt_inc;

  assign load_ok = LOAD && (DIV_IN >= WIDTH'(2));
  assign wrap    = (cnt_q == (div_q - WIDTH'(1)));
  assign cnt_inc = cnt_q + WIDTH'(1);

  // Next-state: a valid load wins over everything, otherwise run/done behaviour.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    sq_d    = sq_q;
    err_d   = 1'b0;

    if (load_ok) begin
      div_d   = DIV_IN;
      cnt_d   = '0;
      sq_d    = 1'b0;
      state_d = StRun;
    end else begin
      // A rejected load behaves exactly like no load, apart from the error pulse.
      err_d = LOAD;
      case (state_q)
        StRun: begin
          if (EN) begin
            if (wrap) begin
              // Next count is 0, which is always below div>>1 since div >= 2.
              cnt_d  = '0;
              tick_d = 1'b1;
              sq_d   = 1'b0;
              if (ONESHOT) begin
                state_d = StDone;
              end
            end else begin
              cnt_d = cnt_inc;
              sq_d  = (cnt_inc >= (div_q >> 1));
            end
          end
        end
        StDone: begin
          cnt_d = '0;
          sq_d  = 1'b0;
          // Leaving DONE does not count on this edge; counting resumes next enabled edge.
          if (!ONESHOT) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // State and output registers, asynchronously reset to the default divisor.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StRun;
      div_q   <= DefDiv;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      sq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      sq_q    <= sq_d;
      err_q   <= err_d;
    end
  end

  assign TICK     = tick_q;
  assign SQ_OUT   = sq_q;
  assign DONE     = (state_q == StDone);
  assign LOAD_ERR = err_q;
  assign CNT      = cnt_q;

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Parametrised, fully synchronous successor to the fixed ÷262144 ripple divider used by the stopwatch.
- Generates one-cycle clock-enable strobes (TICK) and a near-50% square wave (SQ_OUT) from CLK.
- The divisor can be loaded at runtime, and the block has a one-shot mode.
- No derived clocks are produced; all downstream stopwatch logic runs on CLK and qualifies on TICK.

Parameters:
- WIDTH, 19, width of the divisor and of the counter.
- DEFAULT_DIV, 262144, divisor applied at reset. Must satisfy 2 ≤ DEFAULT_DIV ≤ 2^WIDTH−1; violating this is a synthesis/elaboration error.

Ports:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  count enable; counter holds when low.
- LOAD  in  1  single-cycle request to load DIV_IN.
- DIV_IN  in  WIDTH  new divisor N.
- ONESHOT  in  1  0 = periodic, 1 = stop after first TICK.
- TICK  out  1  one-CLK pulse, once per N enabled cycles.
- SQ_OUT  out  1  registered square wave, period N enabled cycles.
- DONE  out  1  high while one-shot has expired.
- LOAD_ERR  out  1  one-cycle pulse when LOAD is rejected.
- CNT  out  WIDTH  current counter value.

Behaviour:
- Reset (RST_N low, asynchronous) sets:
  - div_reg = DEFAULT_DIV
  - CNT = 0
  - TICK = 0, SQ_OUT = 0, DONE = 0, LOAD_ERR = 0
  - state = RUN
- All outputs are registered; there are no combinational input-to-output paths.

- State machine has two states, RUN and DONE. DONE output = (state == DONE).

- RUN, EN=1, no LOAD:
  - CNT <= (CNT == div_reg−1) ? 0 : CNT+1.
  - TICK <= 1 on the edge where CNT == div_reg−1, else 0.
  - With EN held high from the first edge after reset, TICK is high after edge N, 2N, 3N, …
- RUN, EN=0: CNT, SQ_OUT and state hold; TICK <= 0.
- SQ_OUT <= (next CNT ≥ div_reg>>1), updated whenever CNT updates.
  - N=4: CNT 0,1,2,3 gives SQ_OUT 0,0,1,1.
  - Odd N=5: SQ_OUT is high 3 of 5 cycles.
- ONESHOT=1 in RUN: on the wrap edge, TICK <= 1, CNT <= 0, SQ_OUT <= 0, state <= DONE.
- DONE:
  - CNT holds at 0, SQ_OUT = 0, TICK = 0, EN ignored.
  - Leaves to RUN on a valid LOAD, or on ONESHOT = 0. Counting resumes on the next enabled edge.
- ONESHOT changing mid-count in RUN takes effect at the next wrap.

- LOAD, valid (DIV_IN ≥ 2):
  - div_reg <= DIV_IN, CNT <= 0, SQ_OUT <= 0, TICK <= 0, state <= RUN.
  - LOAD has priority over EN and over a coincident wrap; no TICK is emitted for that wrap.
  - The new period starts from the following edge.
- LOAD, invalid (DIV_IN 0 or 1):
  - div_reg unchanged.
  - Counter, state and TICK proceed exactly as if LOAD were low.
  - LOAD_ERR <= 1 for one cycle.
- LOAD_ERR is 0 in every other cycle.
- LOAD held high for multiple cycles reloads every cycle, so the counter stays at 0.

- Arithmetic: all compares are unsigned, WIDTH bits. div_reg−1 never underflows because div_reg ≥ 2 always.
- Maximum divisor is 2^WIDTH−1; CNT never exceeds div_reg−1.
- Reset asserted mid-count or in DONE returns the block immediately to reset values, including div_reg = DEFAULT_DIV.

Test Plan:
- Periodic count: WIDTH=19, default divisor, EN=1 for 600000 cycles.
  - TICK pulses exactly at cycles 262144 and 524288, each one cycle wide.
  - SQ_OUT rises at cycle 131072.
- Runtime load and square wave: LOAD with DIV_IN=5, then EN=1.
  - TICK every 5 cycles.
  - CNT sequence 0,1,2,3,4,0.
  - SQ_OUT pattern 0,0,1,1,1 repeating.
- Invalid loads: LOAD with DIV_IN=1 while CNT=3 (N=5), then DIV_IN=0.
  - LOAD_ERR pulses once for each attempt.
  - CNT continues 4,0; period stays 5.
- One-shot: N=4, ONESHOT=1, EN=1.
  - Exactly one TICK at cycle 4, then DONE=1 and CNT=0 for 20 cycles.
  - LOAD DIV_IN=3 clears DONE; next TICK 3 cycles later.
- Enable gating and collisions:
  - EN toggled 1,0,1,0 at N=4: TICK only after 4 enabled edges.
  - LOAD coincident with the wrap edge: no TICK, CNT=0.
- Reset mid-operation: RST_N pulsed low asynchronously between edges at CNT=2, N=5.
  - All outputs 0 immediately.
  - div_reg back to 262144.
